spi_master: RTL and testbench

- Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, one full-duplex frame per accepted word.
- Drives the external SPI bus towards the team's SPI slave core.
- Generates sclk/cs_n/mosi from the system clock via a programmable divider and captures miso through an internal 2-stage synchronizer.
- Valid/ready word interface on the system side.

---
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, one full-duplex frame per accepted word.
// sclk/cs_n/mosi are registered; miso is sampled through a SYNC_STAGES-deep synchronizer.
module spi_master #(
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 4,
    parameter int CS_GAP      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      tx_sh;
    logic [DATA_W-1:0]      rx_sh;
    logic [SYNC_STAGES-1:0] sync;
    logic                   miso_s;
    logic                   div_done;

    assign miso_s   = sync[SYNC_STAGES-1];
    assign div_done = (cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], miso};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            tx_ready <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (tx_valid) begin
                        // tx_sh holds the bits still to be sent after the MSB now on mosi
                        tx_sh    <= tx_data << 1;
                        mosi     <= tx_data[DATA_W-1];
                        cs_n     <= 1'b0;
                        bit_cnt  <= '0;
                        tx_ready <= 1'b0;
                        state    <= LEAD;
                    end
                end
                LEAD, LOW: begin
                    if (div_done) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_done) begin
                        cnt   <= '0;
                        sclk  <= 1'b0;
                        rx_sh <= {rx_sh[DATA_W-2:0], miso_s};
                        if (bit_cnt == BIT_LAST) begin
                            state <= TRAIL;
                        end else begin
                            mosi    <= tx_sh[DATA_W-1];
                            tx_sh   <= tx_sh << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (div_done) begin
                        cnt      <= '0;
                        cs_n     <= 1'b1;
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of frames (loopback or mode-0 slave model) plus
// hand sequences for reset/idle, back-to-back words and mid-frame abort.
module tb_spi_master;

    localparam int DW = 8;
    localparam int CD = 4;
    localparam int CG = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(DW), .CLK_DIV(CD), .CS_GAP(CG), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    // Mode-0 slave: presents MSB when selected, advances on each sclk falling edge.
    logic          loopback = 1'b1;
    logic [DW-1:0] slave_word = '0;
    int            sidx = DW - 1;
    logic          slave_bit;

    always @(negedge cs_n) sidx = DW - 1;
    always @(negedge sclk) if (!cs_n) sidx = sidx - 1;

    always_comb begin
        slave_bit = 1'b0;
        if (sidx >= 0 && sidx < DW) slave_bit = slave_word[sidx];
    end

    assign miso = loopback ? mosi : slave_bit;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Caller has driven tx_valid/tx_data at a negedge; the next posedge is the accept (cycle 0).
    task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] exp_rx,
                             input bit busy, input bit keep, input logic [DW-1:0] next_tx);
        int t = 1;
        int cs_fall = -1, cs_low = 0, cs_high_tail = 0, rises = 0, hl = 0;
        int bad_high = 0, bad_mosi = 0, rv_cnt = 0, rv_cyc = -1, rdy_cyc = -1;
        logic [DW-1:0] got_mosi = '0;
        logic [DW-1:0] rxd = '0;
        logic prev_sclk = 1'b0;
        logic prev_mosi = 1'b0;
        check("ready_before_accept", int'(tx_ready), 1);
        @(negedge clk);
        if (keep) tx_data = next_tx;
        else tx_valid = 1'b0;
        while (t < 300) begin
            if (!cs_n) begin
                cs_low++;
                if (cs_fall < 0) cs_fall = t;
            end else if (cs_fall >= 0) begin
                cs_high_tail++;
            end
            if (sclk && !prev_sclk) begin
                rises++;
                if (rises <= DW) got_mosi[DW-rises] = mosi;
                hl = 0;
            end
            if (sclk) hl++;
            if (!sclk && prev_sclk && hl != CD) bad_high++;
            if (sclk && prev_sclk && mosi !== prev_mosi) bad_mosi++;
            prev_sclk = sclk;
            prev_mosi = mosi;
            if (rx_valid) begin
                rv_cnt++;
                rv_cyc = t;
                rxd = rx_data;
            end
            if (tx_ready) begin
                rdy_cyc = t;
                break;
            end
            if (busy) begin
                tx_valid = 1'($urandom);
                tx_data  = DW'($urandom);
            end
            @(negedge clk);
            t++;
        end
        if (!keep) tx_valid = 1'b0;
        check("cs_fall_cycle", cs_fall, 1);
        check("cs_low_len", cs_low, CD * (2 * DW + 1));
        check("cs_high_after_frame", cs_high_tail, CG + 1);
        check("sclk_rises", rises, DW);
        check("sclk_bad_high", bad_high, 0);
        check("mosi_change_sclk_high", bad_mosi, 0);
        check("mosi_bits", int'(got_mosi), int'(tx));
        check("rx_valid_pulses", rv_cnt, 1);
        check("rx_valid_cycle", rv_cyc, 1 + CD * (2 * DW + 1));
        check("rx_data_at_pulse", int'(rxd), int'(exp_rx));
        check("rx_data_held", int'(rx_data), int'(exp_rx));
        check("tx_ready_cycle", rdy_cyc, 1 + CD * (2 * DW + 1) + CG);
    endtask

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] slave;
        bit            lb;
        bit            busy;
        logic [DW-1:0] exp_rx;
    } vec_t;

    initial begin
        vec_t vecs[5];
        vecs[0] = '{tx: 8'hA5, slave: 8'h00, lb: 1'b1, busy: 1'b0, exp_rx: 8'hA5};
        vecs[1] = '{tx: 8'hFF, slave: 8'h3C, lb: 1'b0, busy: 1'b0, exp_rx: 8'h3C};
        vecs[2] = '{tx: 8'h00, slave: 8'h81, lb: 1'b0, busy: 1'b0, exp_rx: 8'h81};
        vecs[3] = '{tx: 8'h5A, slave: 8'hC3, lb: 1'b0, busy: 1'b1, exp_rx: 8'hC3};
        vecs[4] = '{tx: 8'h96, slave: 8'h00, lb: 1'b1, busy: 1'b1, exp_rx: 8'h96};

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_static", int'({cs_n, sclk, mosi, tx_ready, rx_valid}), 5'b10010);
        end

        for (int i = 0; i < 5; i++) begin
            loopback   = vecs[i].lb;
            slave_word = vecs[i].slave;
            tx_valid   = 1'b1;
            tx_data    = vecs[i].tx;
            run_frame(vecs[i].tx, vecs[i].exp_rx, vecs[i].busy, 1'b0, '0);
            repeat (3) @(negedge clk);
        end

        // Back-to-back with tx_valid held; tx_data switches right after the first accept
        loopback = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        run_frame(8'h01, 8'h01, 1'b0, 1'b1, 8'h80);
        run_frame(8'h80, 8'h80, 1'b0, 1'b0, '0);

        // Abort at cycle 30 of a frame
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (29) @(negedge clk);
        check("pre_abort_cs_low", int'(cs_n), 0);
        rst = 1'b1;
        #1;
        check("abort_cs_n", int'(cs_n), 1);
        check("abort_sclk", int'(sclk), 0);
        check("abort_mosi", int'(mosi), 0);
        check("abort_tx_ready", int'(tx_ready), 1);
        check("abort_rx_data", int'(rx_data), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_rx_valid", int'(rx_valid), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h69;
        run_frame(8'h69, 8'h69, 1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
